// File: rtl/orv64_bp_ctrl.sv
// Debug-halt controller: breakpoint slot registers plus run/drain/halt/step sequencer.
// Optional 16-bit breakpoint hit counter at register 11 when ORV64_BP_HIT_CNT_EN is defined.
module orv64_bp_ctrl #(
    parameter int NUM_SLOTS = 4,
    parameter int VADDR_W   = 39,
    parameter int DATA_W    = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic                         cfg_wr,
    input  logic [3:0]                   cfg_addr,
    input  logic [DATA_W-1:0]            cfg_wdata,
    output logic                         cfg_rvalid,
    output logic [DATA_W-1:0]            cfg_rdata,
    output logic [NUM_SLOTS*VADDR_W-1:0] bp_if_pc,
    output logic [NUM_SLOTS-1:0]         en_bp_if_pc,
    output logic [NUM_SLOTS*VADDR_W-1:0] bp_wb_pc,
    output logic [NUM_SLOTS-1:0]         en_bp_wb_pc,
    output logic                         instret_bp_en,
    output logic [DATA_W-1:0]            instret_bp,
    input  logic                         bp_stall,
    input  logic                         halt_req,
    input  logic                         resume_req,
    input  logic                         step_req,
    input  logic                         wb_valid,
    input  logic                         pipe_idle,
    output logic                         core_stall,
    output logic                         halted,
    output logic [1:0]                   halt_cause
);

    localparam int MASK_W = 2 * NUM_SLOTS + 1;

    localparam logic [3:0] ADDR_MASK    = 4'd8;
    localparam logic [3:0] ADDR_INSTRET = 4'd9;
    localparam logic [3:0] ADDR_STATUS  = 4'd10;
`ifdef ORV64_BP_HIT_CNT_EN
    localparam logic [3:0] ADDR_HITCNT  = 4'd11;
`endif

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_EXT  = 2'd1;
    localparam logic [1:0] CAUSE_BP   = 2'd2;
    localparam logic [1:0] CAUSE_STEP = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_HALTED   = 2'd2,
        ST_STEP_RES = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          cause_q, cause_d;
    logic                is_step_q, is_step_d;
    logic                halted_q, halted_d;

    logic [VADDR_W-1:0]  if_pc_q [NUM_SLOTS];
    logic [VADDR_W-1:0]  if_pc_d [NUM_SLOTS];
    logic [VADDR_W-1:0]  wb_pc_q [NUM_SLOTS];
    logic [VADDR_W-1:0]  wb_pc_d [NUM_SLOTS];
    logic [MASK_W-1:0]   mask_q, mask_d;
    logic [DATA_W-1:0]   instret_q, instret_d;

    logic                rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [DATA_W-1:0]   rd_val;

    logic                cfg_wen;
    logic                cfg_ren;
    logic                mask_n;

    assign cfg_ready = cfg_valid;
    assign cfg_wen   = cfg_valid & cfg_wr;
    assign cfg_ren   = cfg_valid & ~cfg_wr;

`ifdef ORV64_BP_HIT_CNT_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;

    // Clear from the bus wins over a same-cycle increment.
    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (cfg_wen && cfg_addr == ADDR_HITCNT) begin
            hit_cnt_d = 16'h0000;
        end else if (state_q == ST_RUN && bp_stall && hit_cnt_q != 16'hFFFF) begin
            hit_cnt_d = hit_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q <= 16'h0000;
        end else begin
            hit_cnt_q <= hit_cnt_d;
        end
    end
`endif

    // Configuration register writes
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if_pc_d[i] = if_pc_q[i];
            wb_pc_d[i] = wb_pc_q[i];
        end
        mask_d    = mask_q;
        instret_d = instret_q;
        if (cfg_wen) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (cfg_addr == 4'(i)) begin
                    if_pc_d[i] = cfg_wdata[VADDR_W-1:0];
                end
                if (cfg_addr == 4'(NUM_SLOTS + i)) begin
                    wb_pc_d[i] = cfg_wdata[VADDR_W-1:0];
                end
            end
            if (cfg_addr == ADDR_MASK) begin
                mask_d = cfg_wdata[MASK_W-1:0];
            end
            if (cfg_addr == ADDR_INSTRET) begin
                instret_d = cfg_wdata;
            end
        end
    end

    // Read mux; unmapped addresses fall through as zero.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (cfg_addr == 4'(i)) begin
                rd_val = {{(DATA_W-VADDR_W){1'b0}}, if_pc_q[i]};
            end
            if (cfg_addr == 4'(NUM_SLOTS + i)) begin
                rd_val = {{(DATA_W-VADDR_W){1'b0}}, wb_pc_q[i]};
            end
        end
        if (cfg_addr == ADDR_MASK) begin
            rd_val = {{(DATA_W-MASK_W){1'b0}}, mask_q};
        end
        if (cfg_addr == ADDR_INSTRET) begin
            rd_val = instret_q;
        end
        if (cfg_addr == ADDR_STATUS) begin
            rd_val = {{(DATA_W-4){1'b0}}, cause_q, state_q};
        end
`ifdef ORV64_BP_HIT_CNT_EN
        if (cfg_addr == ADDR_HITCNT) begin
            rd_val = {{(DATA_W-16){1'b0}}, hit_cnt_q};
        end
`endif
    end

    always_comb begin
        rvalid_d = cfg_ren;
        rdata_d  = rdata_q;
        if (cfg_ren) begin
            rdata_d = rd_val;
        end
    end

    // Halt sequencer
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        is_step_d = is_step_q;
        case (state_q)
            ST_RUN: begin
                if (bp_stall) begin
                    state_d = ST_DRAIN;
                    cause_d = CAUSE_BP;
                end else if (halt_req) begin
                    state_d = ST_DRAIN;
                    cause_d = CAUSE_EXT;
                end
            end
            ST_DRAIN: begin
                if (pipe_idle) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (step_req) begin
                    state_d   = ST_STEP_RES;
                    is_step_d = 1'b1;
                end else if (resume_req) begin
                    state_d   = ST_STEP_RES;
                    is_step_d = 1'b0;
                    cause_d   = CAUSE_NONE;
                end
            end
            ST_STEP_RES: begin
                // Breakpoints stay masked until one instruction retires.
                if (wb_valid) begin
                    if (is_step_q) begin
                        state_d = ST_DRAIN;
                        cause_d = CAUSE_STEP;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
        halted_d = (state_q == ST_HALTED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            cause_q   <= CAUSE_NONE;
            is_step_q <= 1'b0;
            halted_q  <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if_pc_q[i] <= '0;
                wb_pc_q[i] <= '0;
            end
            mask_q    <= '0;
            instret_q <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            is_step_q <= is_step_d;
            halted_q  <= halted_d;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if_pc_q[i] <= if_pc_d[i];
                wb_pc_q[i] <= wb_pc_d[i];
            end
            mask_q    <= mask_d;
            instret_q <= instret_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign mask_n = (state_q != ST_STEP_RES);

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            bp_if_pc[i*VADDR_W +: VADDR_W] = if_pc_q[i];
            bp_wb_pc[i*VADDR_W +: VADDR_W] = wb_pc_q[i];
        end
    end

    assign en_bp_if_pc   = mask_q[NUM_SLOTS-1:0] & {NUM_SLOTS{mask_n}};
    assign en_bp_wb_pc   = mask_q[2*NUM_SLOTS-1:NUM_SLOTS] & {NUM_SLOTS{mask_n}};
    assign instret_bp_en = mask_q[2*NUM_SLOTS] & mask_n;
    assign instret_bp    = instret_q;

    assign core_stall = (state_q == ST_DRAIN) || (state_q == ST_HALTED);
    assign halted     = halted_q;
    assign halt_cause = cause_q;
    assign cfg_rvalid = rvalid_q;
    assign cfg_rdata  = rdata_q;

endmodule
